reg_file_sb: RTL and testbench
==============================

Name: reg_file_sb

Overview:
Parametrised, clocked successor to the MIPS datapath register file. It provides N read ports, one write port, and a hardwired zero register. An optional write-to-read bypass is included. A per-register scoreboard of pending writes lets the pipeline control detect RAW hazards. It sits between the decode stage (reads and issue) and the writeback stage (writes and scoreboard release).

Parameters:
DATA_W, 32, width of each register
NUM_REGS, 32, number of architectural registers (power of two, >=2)
ADDR_W, $clog2(NUM_REGS), register address width (derived, not overridden)
NUM_RD, 2, number of read ports
BYPASS, 1, 1 = same-cycle write data forwarded to matching read ports; 0 = no forwarding
ZERO_REG, 1, 1 = register 0 reads 0, ignores writes, never busy

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-high reset
RegWrite  in  1  writeback enable
AW  in  ADDR_W  writeback address
WriteData  in  DATA_W  writeback data
RA  in  NUM_RD*ADDR_W  read addresses; port k = RA[k*ADDR_W +: ADDR_W]
DR  out  NUM_RD*DATA_W  read data; port k = DR[k*DATA_W +: DATA_W]
RdBusy  out  NUM_RD  port k source has an outstanding write
IssueValid  in  1  instruction issued with a destination register
IssueDst  in  ADDR_W  destination register of the issued instruction
Flush  in  1  discard all pending-write marks
PendingCount  out  ADDR_W+1  number of registers currently marked busy

Behaviour:
- Reset (async, rst=1): all registers cleared to 0, all busy bits cleared, PendingCount=0. DR reflects the cleared array immediately. Reset mid-operation discards any in-flight write.
- Write: on the rising clk edge with RegWrite=1, Reg[AW]<=WriteData. AW=0 with ZERO_REG=1 is ignored.
- Read: combinational, zero latency.
  - DR[k]=Reg[RA[k]].
  - ZERO_REG=1 and RA[k]=0 -> DR[k]=0, with or without a write to 0.
  - BYPASS=1, RegWrite=1, AW==RA[k], RA[k]!=0 (when ZERO_REG) -> DR[k]=WriteData in the same cycle.
  - BYPASS=0 -> DR[k] shows the old value until after the edge.
- Scoreboard: one busy bit per register, updated on the rising clk edge, in this priority order:
  1. Flush=1 clears all bits.
  2. RegWrite=1 clears busy[AW].
  3. IssueValid=1 sets busy[IssueDst].
  - Issue and writeback to the same register in one cycle -> bit stays set (the newer producer wins).
  - Flush together with IssueValid -> only busy[IssueDst] is set after the edge.
  - Issue to register 0 with ZERO_REG=1 is ignored.
  - Writeback to a non-busy register is legal and leaves the bit at 0.
- RdBusy[k] = busy[RA[k]], except it is forced to 0 when BYPASS=1, RegWrite=1 and AW==RA[k] (the value is being forwarded). RdBusy[k] is always 0 for register 0 when ZERO_REG=1.
- PendingCount: registered population count of the busy bits. Updated on the same edge as the bits; never exceeds NUM_REGS-ZERO_REG.
- Multiple read ports may address the same register; each port is resolved independently.

Decomposition:
- Shared package rf_pkg holds:
  - constants DATA_W_DEF=32, NUM_REGS_DEF=32
  - localparam function for ADDR_W
  - typedef for the packed read-address and read-data bundles
- Sub-module reg_scoreboard holds the busy bits, the priority update and the PendingCount counter.
  - Inputs: Flush, RegWrite/AW, IssueValid/IssueDst.
  - Outputs: the busy vector and the count.
- The top level instantiates reg_scoreboard and holds the data array, the read muxes and the bypass logic.

Test Plan:
- Async reset: write 0xDEADBEEF to r5, then assert rst between clock edges -> DR(RA=5)=0 immediately; PendingCount=0.
- Write/read: write 0x12345678 to r7, then read r7 on both ports the next cycle -> both DR=0x12345678, RdBusy=00.
- Zero register: write 0xFFFFFFFF to r0 and issue to r0 -> DR(RA=0)=0, RdBusy=0, PendingCount unchanged.
- Bypass (BYPASS=1): r3 holds 0x1; in the same cycle RegWrite with AW=3, WriteData=0xA5A5A5A5 and RA0=3 -> DR0=0xA5A5A5A5 before the edge, RdBusy[0]=0. Repeat with BYPASS=0 -> DR0=0x1 before the edge.
- Scoreboard: issue r4, then r9 -> PendingCount=2, RdBusy=1 for RA=4. Writeback r4 and issue r4 in the same cycle -> r4 still busy, PendingCount=2. Then writeback r9 -> PendingCount=1.
- Flush priority: busy r2, r6, r8; Flush with IssueValid (IssueDst=11) -> only r11 busy, PendingCount=1.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared constants, address-width helper and default read-port bundle types
// for the register file and its scoreboard.
package rf_pkg;

  localparam int DATA_W_DEF   = 32;
  localparam int NUM_REGS_DEF = 32;
  localparam int NUM_RD_DEF   = 2;

  function automatic int rf_addr_w(input int num_regs);
    return (num_regs < 2) ? 1 : $clog2(num_regs);
  endfunction

  typedef logic [NUM_RD_DEF-1:0][rf_addr_w(NUM_REGS_DEF)-1:0] rd_addr_t;
  typedef logic [NUM_RD_DEF-1:0][DATA_W_DEF-1:0]              rd_data_t;

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: one busy bit per register plus a registered
// population count, updated with flush > writeback > issue priority.
module reg_scoreboard
  import rf_pkg::*;
#(
  parameter  int NUM_REGS = NUM_REGS_DEF,
  parameter  int ZERO_REG = 1,
  localparam int ADDR_W   = rf_addr_w(NUM_REGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                Flush,
  input  logic                RegWrite,
  input  logic [ADDR_W-1:0]   AW,
  input  logic                IssueValid,
  input  logic [ADDR_W-1:0]   IssueDst,
  output logic [NUM_REGS-1:0] busy,
  output logic [ADDR_W:0]     PendingCount
);

  logic [NUM_REGS-1:0] busy_nxt;
  logic [ADDR_W:0]     cnt_nxt;
  logic                iss_ok;

  assign iss_ok = IssueValid && !((ZERO_REG != 0) && (IssueDst == '0));

  // Issue is applied last so a same-cycle issue/writeback pair leaves the
  // newer producer marked.
  always_comb begin
    busy_nxt = Flush ? '0 : busy;
    if (RegWrite) busy_nxt[AW] = 1'b0;
    if (iss_ok)   busy_nxt[IssueDst] = 1'b1;
    if (ZERO_REG != 0) busy_nxt[0] = 1'b0;
  end

  always_comb begin
    cnt_nxt = '0;
    for (int i = 0; i < NUM_REGS; i++)
      cnt_nxt = cnt_nxt + {{ADDR_W{1'b0}}, busy_nxt[i]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy         <= '0;
      PendingCount <= '0;
    end else begin
      busy         <= busy_nxt;
      PendingCount <= cnt_nxt;
    end
  end

endmodule

// File: rtl/reg_file_sb.sv
// Multi-port register file with optional write-to-read bypass, hardwired
// zero register and a RAW-hazard scoreboard.
module reg_file_sb
  import rf_pkg::*;
#(
  parameter  int DATA_W   = DATA_W_DEF,
  parameter  int NUM_REGS = NUM_REGS_DEF,
  parameter  int NUM_RD   = NUM_RD_DEF,
  parameter  int BYPASS   = 1,
  parameter  int ZERO_REG = 1,
  localparam int ADDR_W   = rf_addr_w(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     RegWrite,
  input  logic [ADDR_W-1:0]        AW,
  input  logic [DATA_W-1:0]        WriteData,
  input  logic [NUM_RD*ADDR_W-1:0] RA,
  output logic [NUM_RD*DATA_W-1:0] DR,
  output logic [NUM_RD-1:0]        RdBusy,
  input  logic                     IssueValid,
  input  logic [ADDR_W-1:0]        IssueDst,
  input  logic                     Flush,
  output logic [ADDR_W:0]          PendingCount
);

  logic [NUM_REGS-1:0][DATA_W-1:0] mem;
  logic [NUM_REGS-1:0]             busy;
  logic [NUM_RD-1:0][ADDR_W-1:0]   ra_v;
  logic [NUM_RD-1:0][DATA_W-1:0]   dr_v;
  logic                            wr_ok;

  assign ra_v  = RA;
  assign DR    = dr_v;
  assign wr_ok = RegWrite && !((ZERO_REG != 0) && (AW == '0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem <= '0;
    end else if (wr_ok) begin
      mem[AW] <= WriteData;
    end
  end

  reg_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk          (clk),
    .rst          (rst),
    .Flush        (Flush),
    .RegWrite     (RegWrite),
    .AW           (AW),
    .IssueValid   (IssueValid),
    .IssueDst     (IssueDst),
    .busy         (busy),
    .PendingCount (PendingCount)
  );

  // Each read port resolves zero-register, bypass and array read on its own.
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic is_zero;
    logic hit;

    assign is_zero = (ZERO_REG != 0) && (ra_v[k] == '0);
    assign hit     = (BYPASS != 0) && RegWrite && (AW == ra_v[k]) && !is_zero;

    always_comb begin
      dr_v[k]   = mem[ra_v[k]];
      RdBusy[k] = busy[ra_v[k]];
      if (is_zero) begin
        dr_v[k]   = '0;
        RdBusy[k] = 1'b0;
      end else if (hit) begin
        dr_v[k]   = WriteData;
        RdBusy[k] = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: a bypassing and a non-bypassing instance
// share one stimulus stream and are checked against hand-computed values.
module tb_reg_file_sb;

  localparam int AW_W = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWrite;
  logic [4:0]  AW;
  logic [31:0] WriteData;
  logic [9:0]  RA;
  logic        IssueValid;
  logic [4:0]  IssueDst;
  logic        Flush;

  logic [63:0] dr_b, dr_n;
  logic [1:0]  bsy_b, bsy_n;
  logic [5:0]  pc_b, pc_n;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  reg_file_sb #(.BYPASS(1)) dut (
    .clk(clk), .rst(rst), .RegWrite(RegWrite), .AW(AW), .WriteData(WriteData),
    .RA(RA), .DR(dr_b), .RdBusy(bsy_b), .IssueValid(IssueValid),
    .IssueDst(IssueDst), .Flush(Flush), .PendingCount(pc_b)
  );

  reg_file_sb #(.BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst), .RegWrite(RegWrite), .AW(AW), .WriteData(WriteData),
    .RA(RA), .DR(dr_n), .RdBusy(bsy_n), .IssueValid(IssueValid),
    .IssueDst(IssueDst), .Flush(Flush), .PendingCount(pc_n)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    RegWrite = 0; IssueValid = 0; Flush = 0;
  endtask

  task automatic rd(input logic [4:0] r0, input logic [4:0] r1);
    RA = {r1, r0};
  endtask

  initial begin
    rst = 1; RegWrite = 0; AW = 0; WriteData = 0; RA = 0;
    IssueValid = 0; IssueDst = 0; Flush = 0;
    #1;
    chk("reset_pc", 64'(pc_b), 64'd0);
    chk("reset_dr", dr_b, 64'd0);
    tick();
    rst = 0;
    tick();

    // write + issue same reg: value stored, busy stays set
    RegWrite = 1; AW = 5; WriteData = 32'hDEADBEEF;
    IssueValid = 1; IssueDst = 5;
    tick();
    idle(); rd(5, 5); #1;
    chk("r5_val", 64'(dr_b[31:0]), 64'hDEADBEEF);
    chk("r5_pc", 64'(pc_b), 64'd1);
    chk("r5_busy", 64'(bsy_b), 64'b11);
    #2 rst = 1; #1;
    chk("async_rst_dr", 64'(dr_b[31:0]), 64'd0);
    chk("async_rst_dr_nb", 64'(dr_n[31:0]), 64'd0);
    chk("async_rst_pc", 64'(pc_b), 64'd0);
    tick();
    rst = 0;
    tick();

    // plain write then read on both ports
    RegWrite = 1; AW = 7; WriteData = 32'h12345678;
    tick();
    idle(); rd(7, 7); #1;
    chk("r7_dual", dr_b, {32'h12345678, 32'h12345678});
    chk("r7_dual_nb", dr_n, {32'h12345678, 32'h12345678});
    chk("r7_busy", 64'(bsy_b), 64'b00);

    // zero register: write and issue to r0 are ignored
    RegWrite = 1; AW = 0; WriteData = 32'hFFFFFFFF;
    IssueValid = 1; IssueDst = 0; rd(0, 0); #1;
    chk("r0_bypass", 64'(dr_b[31:0]), 64'd0);
    tick();
    idle(); #1;
    chk("r0_dr", dr_b, 64'd0);
    chk("r0_busy", 64'(bsy_b), 64'b00);
    chk("r0_pc", 64'(pc_b), 64'd0);

    // bypass: r3=1 with a pending issue, then writeback forwarded
    RegWrite = 1; AW = 3; WriteData = 32'h1; IssueValid = 1; IssueDst = 3;
    tick();
    idle(); rd(3, 7); #1;
    chk("r3_busy_pre", 64'(bsy_b), 64'b01);
    RegWrite = 1; AW = 3; WriteData = 32'hA5A5A5A5; #1;
    chk("byp_dr", 64'(dr_b[31:0]), 64'hA5A5A5A5);
    chk("byp_busy", 64'(bsy_b), 64'b00);
    chk("nobyp_dr", 64'(dr_n[31:0]), 64'h1);
    chk("nobyp_busy", 64'(bsy_n), 64'b01);
    tick();
    idle(); #1;
    chk("nobyp_after", 64'(dr_n[31:0]), 64'hA5A5A5A5);
    chk("r3_pc", 64'(pc_b), 64'd0);

    // scoreboard: two issues, overlapping wb/issue, then release
    IssueValid = 1; IssueDst = 4; tick();
    IssueDst = 9; tick();
    idle(); rd(4, 9); #1;
    chk("sb_pc2", 64'(pc_b), 64'd2);
    chk("sb_busy2", 64'(bsy_b), 64'b11);
    RegWrite = 1; AW = 4; WriteData = 32'h44; IssueValid = 1; IssueDst = 4;
    tick();
    idle(); #1;
    chk("sb_wb_iss_pc", 64'(pc_b), 64'd2);
    chk("sb_wb_iss_busy", 64'(bsy_b), 64'b11);
    RegWrite = 1; AW = 9; WriteData = 32'h99;
    tick();
    idle(); #1;
    chk("sb_rel_pc", 64'(pc_b), 64'd1);
    chk("sb_rel_busy", 64'(bsy_b), 64'b01);

    // writeback to a non-busy register leaves the count alone
    RegWrite = 1; AW = 20; WriteData = 32'h20;
    tick();
    idle(); #1;
    chk("wb_idle_pc", 64'(pc_b), 64'd1);

    // flush priority: r4,r2,r6,r8 busy; flush + issue r11
    IssueValid = 1; IssueDst = 2; tick();
    IssueDst = 6; tick();
    IssueDst = 8; tick();
    idle(); #1;
    chk("fl_pre_pc", 64'(pc_b), 64'd4);
    Flush = 1; IssueValid = 1; IssueDst = 11;
    tick();
    idle(); rd(11, 2); #1;
    chk("fl_pc", 64'(pc_b), 64'd1);
    chk("fl_busy", 64'(bsy_b), 64'b01);
    chk("fl_pc_nb", 64'(pc_n), 64'd1);

    // reset held across an edge discards the in-flight write
    RegWrite = 1; AW = 12; WriteData = 32'hCAFEF00D; rd(12, 20);
    #2 rst = 1;
    tick();
    idle(); rst = 0; #1;
    chk("rst_inflight", dr_n, 64'd0);
    chk("rst_inflight_pc", 64'(pc_b), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
